// File: rtl/ima_adpcm_dec_pkg.sv
// Shared IMA ADPCM tables and types. The matching encoder imports this same package,
// so both sides always use the same step and index-adjust tables.
package ima_adpcm_dec_pkg;

  localparam int IDX_MAX = 88;
  localparam logic signed [17:0] PCM_MAX = 18'sd32767;
  localparam logic signed [17:0] PCM_MIN = -18'sd32768;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  // Index adjustment per 3-bit magnitude.
  localparam int ADJ [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  localparam int STEP_TABLE [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };

  // Shift-and-add reconstruction of |difference| from step and magnitude bits.
  function automatic logic [16:0] calc_diff(input logic [14:0] step, input logic [2:0] mag);
    logic [16:0] d;
    d = 17'(step >> 3);
    if (mag[2]) d = d + 17'(step);
    if (mag[1]) d = d + 17'(step >> 1);
    if (mag[0]) d = d + 17'(step >> 2);
    return d;
  endfunction

endpackage

// File: rtl/ima_adpcm_dec_if.sv
// Code-in / sample-out handshake bundle for the IMA ADPCM decoder.
// A transfer happens on a clock edge where valid and ready are both high; valid,
// once raised, holds its data stable until that edge, and ready never depends on valid.
interface ima_adpcm_dec_if;
  logic [3:0]  inPCM;
  logic        inValid;
  logic        inReady;
  logic [15:0] outSamp;
  logic        outValid;
  logic        outReady;
  logic [6:0]  outStepIndex;

  modport master (
    output inPCM, inValid, outReady,
    input  inReady, outSamp, outValid, outStepIndex
  );

  modport slave (
    input  inPCM, inValid, outReady,
    output inReady, outSamp, outValid, outStepIndex
  );
endinterface

// File: rtl/ima_adpcm_dec_step_rom.sv
// Registered-output step-size ROM, one cycle from address to data.
module ima_step_rom
  import ima_adpcm_dec_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  addr,
  output logic [14:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= 15'd0;
    end else if (addr <= 7'(IDX_MAX)) begin
      data <= 15'(STEP_TABLE[addr]);
    end else begin
      data <= 15'd0;
    end
  end

endmodule

// File: rtl/ima_adpcm_dec.sv
// Sequential IMA ADPCM decoder: one 4-bit code in, one saturated 16-bit PCM sample out,
// four clocks per sample at full rate.
module ima_adpcm_dec
  import ima_adpcm_dec_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  ima_adpcm_dec_if.slave bus,
  output state_t         dbg_state
);

  state_t             state, state_nxt;
  logic [3:0]         code;
  logic signed [15:0] pred;
  logic [6:0]         index;
  logic [14:0]        step;

  logic [16:0]        diff;
  logic signed [17:0] sum;
  logic signed [15:0] pred_nxt;
  int                 idx_sum;
  logic [6:0]         index_nxt;

  // The ROM is addressed by the live index; its output is consumed in UPDATE.
  ima_step_rom u_step_rom (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (index),
    .data (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (bus.inValid) state_nxt = ST_STEP;
        ST_STEP:   state_nxt = ST_UPDATE;
        ST_UPDATE: state_nxt = ST_OUT;
        ST_OUT:    if (bus.outReady) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    diff = calc_diff(step, code[2:0]);
    if (code[3]) sum = $signed({{2{pred[15]}}, pred}) - $signed({1'b0, diff});
    else         sum = $signed({{2{pred[15]}}, pred}) + $signed({1'b0, diff});
    if (sum > PCM_MAX)      pred_nxt = 16'sh7FFF;
    else if (sum < PCM_MIN) pred_nxt = -16'sh8000;
    else                    pred_nxt = sum[15:0];

    idx_sum = int'(index) + ADJ[code[2:0]];
    if (idx_sum < 0)            index_nxt = 7'd0;
    else if (idx_sum > IDX_MAX) index_nxt = 7'(IDX_MAX);
    else                        index_nxt = 7'(idx_sum);
  end

  // pred doubles as the output sample register, so it only moves in UPDATE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code  <= 4'd0;
      pred  <= 16'sd0;
      index <= 7'd0;
    end else if (clear) begin
      pred  <= 16'sd0;
      index <= 7'd0;
    end else begin
      if (bus.inValid && bus.inReady) code <= bus.inPCM;
      if (state == ST_UPDATE) begin
        pred  <= pred_nxt;
        index <= index_nxt;
      end
    end
  end

  assign bus.inReady      = (state == ST_IDLE) && !clear;
  assign bus.outValid     = (state == ST_OUT);
  assign bus.outSamp      = pred;
  assign bus.outStepIndex = index;
  assign dbg_state        = state;

endmodule

// File: tb/tb_ima_adpcm_dec.sv
// Directed bench for ima_adpcm_dec: hand-computed IMA decode vectors, latency,
// saturation, index floor, backpressure, clear and asynchronous reset.
module tb_ima_adpcm_dec;
  import ima_adpcm_dec_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   clear = 1'b0;
  state_t dbg_state;
  int     n_cmp = 0;
  int     n_err = 0;

  ima_adpcm_dec_if bus ();

  ima_adpcm_dec dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_code(input logic [3:0] c, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.inPCM   = c;
    bus.inValid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.inReady) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 bus.inValid = 1'b0;
  endtask

  task automatic collect(output logic [15:0] samp, output logic [6:0] idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.outValid) begin
        ok = 1'b1;
        break;
      end
    end
    samp = bus.outSamp;
    idx  = bus.outStepIndex;
    if (ok) begin
      bus.outReady = 1'b1;
      @(posedge clk);
      #1 bus.outReady = 1'b0;
    end
  endtask

  task automatic run_code(input logic [3:0] c, output logic [15:0] samp,
                          output logic [6:0] idx, output bit ok);
    bit ok_in, ok_out;
    drive_code(c, ok_in);
    collect(samp, idx, ok_out);
    ok = ok_in && ok_out;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL reset_outValid got %b want 0", bus.outValid); end
    n_cmp++; if (bus.outSamp !== 16'h0000) begin n_err++; $display("FAIL reset_outSamp got %h want 0000", bus.outSamp); end
    n_cmp++; if (bus.outStepIndex !== 7'd0) begin n_err++; $display("FAIL reset_index got %0d want 0", bus.outStepIndex); end
    n_cmp++; if (bus.inReady !== 1'b1) begin n_err++; $display("FAIL reset_inReady got %b want 1", bus.inReady); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_first_code();
    bit ok;
    drive_code(4'h7, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL first_accept got timeout want accepted"); end
    n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL first_lat_e0 got %b want 0", bus.outValid); end
    @(posedge clk); #1;
    n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL first_lat_e1 got %b want 0", bus.outValid); end
    @(posedge clk); #1;
    n_cmp++; if (bus.outValid !== 1'b1) begin n_err++; $display("FAIL first_lat_e2 got %b want 1", bus.outValid); end
    n_cmp++; if (bus.outSamp !== 16'd11) begin n_err++; $display("FAIL first_samp got %0d want 11", $signed(bus.outSamp)); end
    n_cmp++; if (bus.outStepIndex !== 7'd8) begin n_err++; $display("FAIL first_index got %0d want 8", bus.outStepIndex); end
    bus.outReady = 1'b1;
    @(posedge clk);
    #1 bus.outReady = 1'b0;
    n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL first_consumed got %b want 0", bus.outValid); end
    n_cmp++; if (bus.inReady !== 1'b1) begin n_err++; $display("FAIL first_ready_again got %b want 1", bus.inReady); end
  endtask

  task automatic test_second_code();
    logic [15:0] s; logic [6:0] x; bit ok;
    run_code(4'h8, s, x, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL second_handshake got timeout want done"); end
    n_cmp++; if (s !== 16'd9) begin n_err++; $display("FAIL second_samp got %0d want 9", $signed(s)); end
    n_cmp++; if (x !== 7'd7) begin n_err++; $display("FAIL second_index got %0d want 7", x); end
  endtask

  task automatic test_saturation();
    logic [15:0] s; logic [6:0] x; bit ok; bit all_ok;
    all_ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      run_code(4'h7, s, x, ok);
      all_ok &= ok;
    end
    n_cmp++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL sat_pos_handshake got timeout want done"); end
    n_cmp++; if (s !== 16'h7FFF) begin n_err++; $display("FAIL sat_pos_samp got %0d want 32767", $signed(s)); end
    n_cmp++; if (x !== 7'd88) begin n_err++; $display("FAIL sat_pos_index got %0d want 88", x); end
    // step 32767 gives diff 61436: one negative step lands at -28669, not yet clipped
    run_code(4'hF, s, x, ok);
    n_cmp++; if (s !== 16'h9003) begin n_err++; $display("FAIL sat_first_neg got %0d want -28669", $signed(s)); end
    n_cmp++; if (x !== 7'd88) begin n_err++; $display("FAIL sat_first_neg_index got %0d want 88", x); end
    for (int i = 0; i < 4; i++) begin
      run_code(4'hF, s, x, ok);
      all_ok &= ok;
    end
    n_cmp++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL sat_neg_handshake got timeout want done"); end
    n_cmp++; if (s !== 16'h8000) begin n_err++; $display("FAIL sat_neg_samp got %0d want -32768", $signed(s)); end
    n_cmp++; if (x !== 7'd88) begin n_err++; $display("FAIL sat_neg_index got %0d want 88", x); end
  endtask

  task automatic test_index_floor();
    logic [15:0] s; logic [6:0] x; bit ok;
    do_clear();
    #1;
    n_cmp++; if (bus.outStepIndex !== 7'd0) begin n_err++; $display("FAIL clear_index got %0d want 0", bus.outStepIndex); end
    n_cmp++; if (bus.outSamp !== 16'd0) begin n_err++; $display("FAIL clear_samp got %0d want 0", $signed(bus.outSamp)); end
    run_code(4'h0, s, x, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL floor_handshake got timeout want done"); end
    n_cmp++; if (s !== 16'd0) begin n_err++; $display("FAIL floor_samp got %0d want 0", $signed(s)); end
    n_cmp++; if (x !== 7'd0) begin n_err++; $display("FAIL floor_index got %0d want 0", x); end
  endtask

  task automatic test_stream();
    logic [3:0]  codes [3] = '{4'h3, 4'h5, 4'hB};
    logic [15:0] exp_s [3] = '{16'd4, 16'd12, 16'd4};
    logic [6:0]  exp_x [3] = '{7'd0, 7'd4, 7'd3};
    logic [15:0] s; logic [6:0] x; bit ok;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      run_code(codes[i], s, x, ok);
      n_cmp++; if (ok !== 1'b1 || s !== exp_s[i]) begin n_err++; $display("FAIL stream_samp[%0d] got %0d want %0d", i, $signed(s), $signed(exp_s[i])); end
      n_cmp++; if (x !== exp_x[i]) begin n_err++; $display("FAIL stream_index[%0d] got %0d want %0d", i, x, exp_x[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] s; logic [6:0] x; bit ok; bit seen;
    do_clear();
    drive_code(4'h7, ok);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.outValid) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL bp_outvalid got timeout want 1"); end
    bus.inPCM   = 4'h8;
    bus.inValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (bus.outValid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, bus.outValid); end
      n_cmp++; if (bus.outSamp !== 16'd11) begin n_err++; $display("FAIL bp_hold_samp[%0d] got %0d want 11", i, $signed(bus.outSamp)); end
      n_cmp++; if (bus.inReady !== 1'b0) begin n_err++; $display("FAIL bp_inready[%0d] got %b want 0", i, bus.inReady); end
      @(negedge clk);
    end
    bus.outReady = 1'b1;
    @(posedge clk);
    #1 bus.outReady = 1'b0;
    n_cmp++; if (bus.inReady !== 1'b1) begin n_err++; $display("FAIL bp_ready_after got %b want 1", bus.inReady); end
    @(posedge clk);
    #1 bus.inValid = 1'b0;
    n_cmp++; if (dbg_state !== ST_STEP) begin n_err++; $display("FAIL bp_next_accept got %0d want %0d", dbg_state, ST_STEP); end
    collect(s, x, ok);
    n_cmp++; if (ok !== 1'b1 || s !== 16'd9) begin n_err++; $display("FAIL bp_next_samp got %0d want 9", $signed(s)); end
    n_cmp++; if (x !== 7'd7) begin n_err++; $display("FAIL bp_next_index got %0d want 7", x); end
  endtask

  task automatic test_restart();
    logic [15:0] s; logic [6:0] x; bit ok; bit seen;
    do_clear();
    drive_code(4'h2, ok);
    n_cmp++; if (dbg_state !== ST_STEP) begin n_err++; $display("FAIL restart_in_step got %0d want %0d", dbg_state, ST_STEP); end
    clear = 1'b1;
    bus.inPCM = 4'h7;
    bus.inValid = 1'b1;
    #1;
    n_cmp++; if (bus.inReady !== 1'b0) begin n_err++; $display("FAIL restart_clear_blocks got %b want 0", bus.inReady); end
    @(posedge clk);
    #1 clear = 1'b0;
    bus.inValid = 1'b0;
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL restart_idle got %0d want %0d", dbg_state, ST_IDLE); end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.outValid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL restart_dropped got %b want 0", seen); end
    n_cmp++; if (bus.outStepIndex !== 7'd0) begin n_err++; $display("FAIL restart_index got %0d want 0", bus.outStepIndex); end
    run_code(4'h7, s, x, ok);
    n_cmp++; if (ok !== 1'b1 || s !== 16'd11) begin n_err++; $display("FAIL restart_samp got %0d want 11", $signed(s)); end
    n_cmp++; if (x !== 7'd8) begin n_err++; $display("FAIL restart_next_index got %0d want 8", x); end
  endtask

  task automatic test_async_reset();
    logic [15:0] s; logic [6:0] x; bit ok; bit seen;
    drive_code(4'h7, ok);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL areset_state got %0d want %0d", dbg_state, ST_IDLE); end
    n_cmp++; if (bus.outSamp !== 16'd0) begin n_err++; $display("FAIL areset_samp got %0d want 0", $signed(bus.outSamp)); end
    n_cmp++; if (bus.outStepIndex !== 7'd0) begin n_err++; $display("FAIL areset_index got %0d want 0", bus.outStepIndex); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.outValid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL areset_no_output got %b want 0", seen); end
    run_code(4'h7, s, x, ok);
    n_cmp++; if (ok !== 1'b1 || s !== 16'd11) begin n_err++; $display("FAIL areset_samp_after got %0d want 11", $signed(s)); end
    n_cmp++; if (x !== 7'd8) begin n_err++; $display("FAIL areset_index_after got %0d want 8", x); end
  endtask

  initial begin
    bus.inPCM    = 4'h0;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    test_reset();
    test_first_code();
    test_second_code();
    test_saturation();
    test_index_floor();
    test_stream();
    test_backpressure();
    test_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
